// File: rtl/madnes_tam_pkg.sv
// madnes_tam_pkg: shared types and constants for the TAM tilemap reader.
//   tam_entry_t    : one 16-bit TAM entry {vflip, hflip, palette, tile}
//   tile_rec_t     : one FIFO record (entry + effective fine_y + last flag), 20 bits
//   fetch_state_t  : reader FSM states
//   row_base()     : row * map_w built from shifted adds of the constant's set bits
package madnes_tam_pkg;

    localparam int unsigned MAP_W_C      = 40;
    localparam int unsigned MAP_H_C      = 30;
    localparam int unsigned TILE_PX_LOG2 = 3;
    localparam int unsigned SCREEN_H     = 240;

    typedef struct packed {
        logic       vflip;
        logic       hflip;
        logic [3:0] palette;
        logic [9:0] tile;
    } tam_entry_t;

    typedef struct packed {
        tam_entry_t entry;
        logic [2:0] fine_y;
        logic       last;
    } tile_rec_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } fetch_state_t;

    // map_w is an elaboration constant, so this reduces to a fixed adder tree.
    function automatic logic [10:0] row_base(input logic [5:0] row, input int unsigned map_w);
        logic [10:0] acc;
        acc = '0;
        for (int unsigned b = 0; b < 11; b++) begin
            if (map_w[b]) acc = acc + (11'(row) << b);
        end
        return acc;
    endfunction

endpackage

// File: rtl/tam_fetch_fifo.sv
// tam_fetch_fifo: synchronous FIFO for tile records (registered storage, read data
// presented from the head entry).
//   clk, rst_n : clock, asynchronous active-low reset (storage cleared too)
//   flush      : empties the FIFO; has priority over push/pop
//   push, wr_data : write request and data; accepted when not full or when popping
//   pop        : read request; ignored when empty
//   rd_data    : head entry
//   full, empty: occupancy flags
module tam_fetch_fifo #(
    parameter int unsigned WIDTH = 20,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rd_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr[AW-1:0]] <= wr_data;
                wr_ptr              <= wr_ptr + (AW+1)'(1);
            end
            if (do_pop) rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

endmodule

// File: rtl/tam_fetcher.sv
// tam_fetcher: reader side of the TAM tilemap RAM. On line_start it samples the
// scroll/line inputs, then walks MAP_W+1 entries of one map row (wrapping the
// column), decodes them and queues per-tile records for the pixel pipeline.
//   clk, rst_n                  : clock, asynchronous active-low reset
//   line_start, line_y, scroll_x, scroll_y : per-line sample inputs
//   tam_read_addr / tam_read_data : registered RAM address, combinational read data
//   out_valid / out_ready        : record handshake
//   out_tile, out_palette, out_hflip, out_vflip, out_fine_y, out_last : record fields
//   fine_x                      : scroll_x[2:0] latched at line_start
//   line_done                   : pulse after the last record of a line is accepted
//   stat_underruns              : underrun counter, built only with TAM_FETCH_STATS_EN
// Optional feature macro: TAM_FETCH_STATS_EN.
module tam_fetcher
    import madnes_tam_pkg::*;
#(
    parameter int unsigned MAP_W      = MAP_W_C,
    parameter int unsigned MAP_H      = MAP_H_C,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        line_start,
    input  logic [7:0]  line_y,
    input  logic [8:0]  scroll_x,
    input  logic [7:0]  scroll_y,
    output logic [10:0] tam_read_addr,
    input  logic [15:0] tam_read_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [9:0]  out_tile,
    output logic [3:0]  out_palette,
    output logic        out_hflip,
    output logic        out_vflip,
    output logic [2:0]  out_fine_y,
    output logic        out_last,
    output logic [2:0]  fine_x,
    output logic        line_done,
    output logic [15:0] stat_underruns
);

    localparam int unsigned CW = $clog2(MAP_W + 1);

    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("tam_fetcher: FIFO_DEPTH must be a power of two, at least 2");
    end
    if (MAP_W > 63 || MAP_W * MAP_H > 2048) begin : g_bad_map
        $error("tam_fetcher: map does not fit the 11-bit TAM address space");
    end

    fetch_state_t    state;
    logic [10:0]     base;
    logic [5:0]      col;
    logic [5:0]      col_n;
    logic [CW-1:0]   count;
    logic [2:0]      fy;

    logic [8:0]      y_sum;
    logic [8:0]      y_eff;
    logic [5:0]      row_s;
    logic [5:0]      col_s;
    logic [10:0]     base_s;

    logic            push;
    logic            pop;
    logic            fifo_full;
    logic            fifo_empty;
    tile_rec_t       wr_rec;
    tile_rec_t       rd_rec;
    logic [$bits(tile_rec_t)-1:0] fifo_rd;

    // Line sample: wrap y into the screen, first column into the map.
    always_comb begin
        y_sum = {1'b0, line_y} + {1'b0, scroll_y};
        y_eff = (y_sum >= 9'(SCREEN_H)) ? y_sum - 9'(SCREEN_H) : y_sum;
        row_s = y_eff[8:TILE_PX_LOG2];
        col_s = scroll_x[8:TILE_PX_LOG2];
        if (col_s >= 6'(MAP_W)) col_s = col_s - 6'(MAP_W);
        base_s = row_base(row_s, MAP_W);
    end

    assign col_n = (col == 6'(MAP_W - 1)) ? '0 : col + 6'd1;

    assign out_valid = !fifo_empty;
    assign pop       = out_valid && out_ready;
    // A full FIFO still takes an entry when the head leaves in the same cycle.
    assign push      = (state == FETCH) && !line_start && (!fifo_full || pop);

    always_comb begin
        wr_rec.entry  = tam_entry_t'(tam_read_data);
        wr_rec.fine_y = wr_rec.entry.vflip ? 3'd7 - fy : fy;
        wr_rec.last   = (count == CW'(MAP_W));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            base          <= '0;
            col           <= '0;
            count         <= '0;
            fy            <= '0;
            fine_x        <= '0;
            tam_read_addr <= '0;
            line_done     <= 1'b0;
        end else begin
            line_done <= pop && rd_rec.last;
            if (line_start) begin
                // Restart from the new sample in any state; the FIFO flushes alongside.
                state         <= FETCH;
                base          <= base_s;
                col           <= col_s;
                count         <= '0;
                fy            <= y_eff[TILE_PX_LOG2-1:0];
                fine_x        <= scroll_x[2:0];
                tam_read_addr <= base_s + 11'(col_s);
            end else begin
                case (state)
                    FETCH: begin
                        if (push) begin
                            count         <= count + CW'(1);
                            col           <= col_n;
                            tam_read_addr <= base + 11'(col_n);
                            if (count == CW'(MAP_W)) state <= DRAIN;
                        end
                    end
                    DRAIN: begin
                        if (pop && rd_rec.last) state <= IDLE;
                    end
                    default: ;
                endcase
            end
        end
    end

    tam_fetch_fifo #(
        .WIDTH ($bits(tile_rec_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush   (line_start),
        .push    (push),
        .wr_data (wr_rec),
        .pop     (pop),
        .rd_data (fifo_rd),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign rd_rec      = tile_rec_t'(fifo_rd);
    assign out_tile    = rd_rec.entry.tile;
    assign out_palette = rd_rec.entry.palette;
    assign out_hflip   = rd_rec.entry.hflip;
    assign out_vflip   = rd_rec.entry.vflip;
    assign out_fine_y  = rd_rec.fine_y;
    assign out_last    = rd_rec.last;

`ifdef TAM_FETCH_STATS_EN
    logic [15:0] underruns;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            underruns <= '0;
        end else if (state != IDLE && out_ready && !out_valid && underruns != '1) begin
            underruns <= underruns + 16'd1;
        end
    end

    assign stat_underruns = underruns;
`else
    assign stat_underruns = '0;
`endif

endmodule

// File: tb/tb_tam_fetcher.sv
// tb_tam_fetcher: randomized scoreboard bench for tam_fetcher.
module tb_tam_fetcher;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        line_start = 1'b0;
    logic [7:0]  line_y = '0;
    logic [8:0]  scroll_x = '0;
    logic [7:0]  scroll_y = '0;
    logic [10:0] tam_read_addr;
    logic [15:0] tam_read_data;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [9:0]  out_tile;
    logic [3:0]  out_palette;
    logic        out_hflip;
    logic        out_vflip;
    logic [2:0]  out_fine_y;
    logic        out_last;
    logic [2:0]  fine_x;
    logic        line_done;
    logic [15:0] stat_underruns;

    logic [15:0] ram [0:2047];
    assign tam_read_data = ram[tam_read_addr];

    always #5 clk = ~clk;

    tam_fetcher #(.MAP_W(40), .MAP_H(30), .FIFO_DEPTH(4)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .line_start     (line_start),
        .line_y         (line_y),
        .scroll_x       (scroll_x),
        .scroll_y       (scroll_y),
        .tam_read_addr  (tam_read_addr),
        .tam_read_data  (tam_read_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_tile       (out_tile),
        .out_palette    (out_palette),
        .out_hflip      (out_hflip),
        .out_vflip      (out_vflip),
        .out_fine_y     (out_fine_y),
        .out_last       (out_last),
        .fine_x         (fine_x),
        .line_done      (line_done),
        .stat_underruns (stat_underruns)
    );

    typedef struct packed {
        logic [9:0] tile;
        logic [3:0] pal;
        logic       h;
        logic       v;
        logic [2:0] fy;
        logic       last;
    } rec_t;

    rec_t        exp_q[$];
    int          checks = 0;
    int          failures = 0;
    int          rdy_mode = 2;      // 0: always ready, 1: ready 1-in-3, 2: held low
    int          accepted = 0;
    bit          pending_done = 0;
    bit          stall_prev = 0;
    rec_t        prev_rec;
    int          exp_first_addr;
    logic [15:0] stat_before;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    // Reference model: one line is MAP_W+1 entries starting at the scrolled column.
    task automatic expect_line(input int ly, input int sx, input int sy);
        int   y;
        int   row;
        int   fyv;
        int   c0;
        int   a;
        logic [15:0] e;
        rec_t r;
        y = ly + sy;
        if (y >= 240) y -= 240;
        row = y / 8;
        fyv = y % 8;
        c0  = sx / 8;
        if (c0 >= 40) c0 -= 40;
        exp_first_addr = row * 40 + c0;
        for (int i = 0; i <= 40; i++) begin
            a      = row * 40 + (c0 + i) % 40;
            e      = ram[a];
            r.tile = e[9:0];
            r.pal  = e[13:10];
            r.h    = e[14];
            r.v    = e[15];
            r.fy   = e[15] ? 3'(7 - fyv) : 3'(fyv);
            r.last = (i == 40);
            exp_q.push_back(r);
        end
    endtask

    // Ready driver, updated after the stimulus writes at posedge+1.
    always @(posedge clk) begin
        #2;
        case (rdy_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = ($urandom_range(0, 2) == 0);
            default: out_ready = 1'b0;
        endcase
    end

    // Monitor: handshake sampled mid-cycle, record popped from the scoreboard.
    always @(negedge clk) begin
        rec_t cur;
        cur = {out_tile, out_palette, out_hflip, out_vflip, out_fine_y, out_last};
        if (rst_n) begin
            if (pending_done || line_done) chk("line_done", 32'(line_done), 32'(pending_done));
            pending_done = 0;
            if (stall_prev) begin
                chk("stall_valid", 32'(out_valid), 32'd1);
                chk("stall_fields", 32'(cur), 32'(prev_rec));
            end
            stall_prev = out_valid && !out_ready && !line_start;
            prev_rec   = cur;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_record", 32'(cur), 32'hFFFFFFFF);
                end else begin
                    chk("record", 32'(cur), 32'(exp_q.pop_front()));
                end
                accepted++;
                if (cur.last) pending_done = 1;
            end
        end else begin
            pending_done = 0;
            stall_prev   = 0;
        end
    end

    task automatic drive_sample(input int ly, input int sx, input int sy);
        line_y     = 8'(ly);
        scroll_x   = 9'(sx);
        scroll_y   = 8'(sy);
        line_start = 1'b1;
    endtask

    task automatic start_line(input int ly, input int sx, input int sy, input int mode);
        @(posedge clk); #1;
        stat_before = stat_underruns;
        expect_line(ly, sx, sy);
        rdy_mode = mode;
        drive_sample(ly, sx, sy);
        @(posedge clk); #1;
        line_start = 1'b0;
        chk("fine_x", 32'(fine_x), 32'(sx % 8));
    endtask

    task automatic finish_line(input bit timed, input bit stat_chk);
        int          cyc;
        logic [15:0] d;
        cyc = 0;
        while (!line_done && cyc < 2000) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) begin
                chk("first_addr", 32'(tam_read_addr), 32'(exp_first_addr));
                chk("valid_cycle1", 32'(out_valid), 32'd0);
            end
            if (cyc == 2) chk("valid_cycle2", 32'(out_valid), 32'd1);
        end
        chk("line_done_seen", 32'(line_done), 32'd1);
        if (timed) chk("line_cycles", 32'(cyc), 32'd43);
        d = stat_underruns - stat_before;
`ifdef TAM_FETCH_STATS_EN
        if (stat_chk) chk("stat_underruns_delta", 32'(d), 32'd1);
`else
        if (stat_chk) chk("stat_underruns_zero", 32'(stat_underruns), 32'd0);
`endif
        @(negedge clk);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc0;
        int n;
        for (int i = 0; i < 2048; i++) ram[i] = 16'(i);

        // Reset values.
        repeat (3) @(posedge clk);
        #1;
        chk("rst_addr", 32'(tam_read_addr), 32'd0);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_fields", 32'({out_tile, out_palette, out_hflip, out_vflip, out_fine_y, out_last}), 32'd0);
        chk("rst_fine_x", 32'(fine_x), 32'd0);
        chk("rst_line_done", 32'(line_done), 32'd0);
        chk("rst_stat", 32'(stat_underruns), 32'd0);
        rst_n = 1'b1;
        rdy_mode = 0;
        repeat (2) @(posedge clk);

        // Identity RAM, no scroll.
        start_line(0, 0, 0, 0);
        finish_line(1, 1);

        // Wrapping y and column.
        start_line(235, 317, 10, 0);
        finish_line(1, 1);

        // Fully flagged entry at the start of row 1.
        for (int i = 0; i < 2048; i++) ram[i] = 16'($urandom);
        ram[40] = 16'hC7FF;
        start_line(8, 0, 0, 0);
        finish_line(1, 1);

        // Back-pressure: ready 1-in-3.
        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < 2048; i++) ram[i] = 16'($urandom);
            start_line($urandom_range(0, 239), $urandom_range(0, 319), $urandom_range(0, 239), 1);
            finish_line(0, 0);
        end

        // Abort after 10 accepted records; the new line must be the only one seen.
        acc0 = accepted;
        start_line($urandom_range(0, 239), $urandom_range(0, 319), $urandom_range(0, 239), 0);
        n = 0;
        while (accepted - acc0 < 10 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        chk("abort_reached_10", 32'(accepted - acc0 >= 10), 32'd1);
        exp_q.delete();
        rdy_mode = 2;
        begin
            int ly2;
            int sx2;
            int sy2;
            ly2 = $urandom_range(0, 239);
            sx2 = $urandom_range(0, 319);
            sy2 = $urandom_range(0, 239);
            expect_line(ly2, sx2, sy2);
            drive_sample(ly2, sx2, sy2);
            @(posedge clk); #1;
            line_start = 1'b0;
            rdy_mode = 0;
            chk("abort_fine_x", 32'(fine_x), 32'(sx2 % 8));
        end
        finish_line(1, 0);

        // Reset in the middle of a line.
        start_line($urandom_range(0, 239), $urandom_range(0, 319), $urandom_range(0, 239), 1);
        repeat (15) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", 32'(out_valid), 32'd0);
        chk("midrst_addr", 32'(tam_read_addr), 32'd0);
        exp_q.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Random lines after reset, mixed ready behaviour.
        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < 2048; i++) ram[i] = 16'($urandom);
            start_line($urandom_range(0, 239), $urandom_range(0, 319), $urandom_range(0, 239), k % 2);
            finish_line(k % 2 == 0, k % 2 == 0);
        end

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
